// File: rtl/sdrc_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdrc_arb_pkg
// Shared definitions for the SDRAM application-port arbiter:
//   - FSM state encoding (IDLE, ISSUE)
//   - rr_pick(): round-robin selection helper
// ---------------------------------------------------------------------------
package sdrc_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Widest requester vector the helper handles.
    localparam int MAX_REQ = 4;

    // Returns the first set bit of req_vector, searching from pointer upward
    // and wrapping modulo nreq. Returns pointer when nothing is set; callers
    // qualify the result with a reduction-OR of the request vector.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] req_vector,
                                           input logic [1:0]         pointer,
                                           input int                 nreq);
        logic [1:0] pick;
        int         idx;
        pick = pointer;
        // Walk from the farthest offset down so the nearest match wins last.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            idx = (int'(pointer) + i) % nreq;
            if (i < nreq && req_vector[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdrc_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// sdrc_arb_tag_fifo
// Small in-order FIFO of requester IDs. One instance tracks accepted reads,
// another accepted writes, so data beats find their owner.
//   sdram_clk, sdram_resetn : clock, async active-low reset
//   push, din               : enqueue an ID (ignored when full)
//   pop                     : dequeue the head (ignored when empty)
//   dout                    : current head, combinational
//   full, empty             : occupancy flags
// ---------------------------------------------------------------------------
module sdrc_arb_tag_fifo
    import sdrc_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         sdram_clk,
    input  logic         sdram_resetn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]  wp_q, rp_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful, and an unreset array maps to plain RAM/flops.
    always_ff @(posedge sdram_clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

    assign dout = mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/sdrc_app_arb.sv
// ---------------------------------------------------------------------------
// sdrc_app_arb
// Round-robin arbiter sharing the SDRAM controller's single app_* request
// port between NREQ requesters, with in-order ID FIFOs steering write-data
// strobes and read-data returns back to the issuing requester.
//   Requester side : req_i/req_addr_i/req_len_i/req_wr_n_i -> req_ack_o
//                    wr_data_i/wr_en_n_i <- wr_next_o
//                    rd_data_o (broadcast), rd_valid_o, last_rd_o
//   Core side      : app_req/app_req_addr/app_req_len/app_req_wr_n, app_req_ack
//                    app_wr_next_req, app_last_wr, app_wr_data, app_wr_en_n
//                    app_rd_valid, app_last_rd, app_rd_data
//   arb_err        : sticky, a data beat arrived while its ID FIFO was empty
// ---------------------------------------------------------------------------
module sdrc_app_arb
    import sdrc_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int APP_AW    = 26,
    parameter int APP_DW    = 32,
    parameter int APP_BW    = 4,
    parameter int bl        = 9,
    parameter int TAG_DEPTH = 4
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_resetn,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*APP_AW-1:0]   req_addr_i,
    input  logic [NREQ*bl-1:0]       req_len_i,
    input  logic [NREQ-1:0]          req_wr_n_i,
    output logic [NREQ-1:0]          req_ack_o,
    input  logic [NREQ*APP_DW-1:0]   wr_data_i,
    input  logic [NREQ*APP_BW-1:0]   wr_en_n_i,
    output logic [NREQ-1:0]          wr_next_o,
    output logic [APP_DW-1:0]        rd_data_o,
    output logic [NREQ-1:0]          rd_valid_o,
    output logic [NREQ-1:0]          last_rd_o,
    output logic                     app_req,
    output logic [APP_AW-1:0]        app_req_addr,
    output logic [bl-1:0]            app_req_len,
    output logic                     app_req_wr_n,
    input  logic                     app_req_ack,
    input  logic                     app_wr_next_req,
    input  logic                     app_last_wr,
    output logic [APP_DW-1:0]        app_wr_data,
    output logic [APP_BW-1:0]        app_wr_en_n,
    input  logic                     app_rd_valid,
    input  logic                     app_last_rd,
    input  logic [APP_DW-1:0]        app_rd_data,
    output logic                     arb_err
);

    logic [0:0]       state_q;
    logic [ID_W-1:0]  rr_q, sel_q, pick, wsel, rsel;
    logic [NREQ-1:0]  eligible;
    logic [APP_AW-1:0] pick_addr;
    logic [bl-1:0]    pick_len;
    logic             pick_wr_n;
    logic             grant_done, push_wr, push_rd, pop_wr, pop_rd;
    logic             wr_full, wr_empty, rd_full, rd_empty;

    // A requester competes only if its direction still has an ID slot, so a
    // full FIFO stalls one direction without blocking the other.
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave a value held (which would infer a latch).
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NREQ; k++)
            eligible[k] = req_i[k] && !(req_wr_n_i[k] ? rd_full : wr_full);
    end

    assign pick = ID_W'(rr_pick(MAX_REQ'(eligible), 2'(rr_q), NREQ));

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        pick_wr_n = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (pick == ID_W'(k)) begin
                pick_addr = req_addr_i[k*APP_AW +: APP_AW];
                pick_len  = req_len_i[k*bl +: bl];
                pick_wr_n = req_wr_n_i[k];
            end
        end
    end

    // Command registers double as the core-facing outputs, so the request
    // stays stable for the whole ISSUE phase.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            sel_q        <= '0;
            app_req      <= 1'b0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        sel_q        <= pick;
                        app_req_addr <= pick_addr;
                        app_req_len  <= pick_len;
                        app_req_wr_n <= pick_wr_n;
                        app_req      <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                default: begin
                    if (app_req_ack) begin
                        app_req <= 1'b0;
                        rr_q    <= (sel_q == ID_W'(NREQ - 1)) ? '0 : sel_q + ID_W'(1);
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign grant_done = (state_q == ST_ISSUE) && app_req_ack;
    assign push_wr    = grant_done && !app_req_wr_n;
    assign push_rd    = grant_done && app_req_wr_n;

    always_comb begin
        req_ack_o = '0;
        for (int k = 0; k < NREQ; k++)
            if (grant_done && sel_q == ID_W'(k)) req_ack_o[k] = 1'b1;
    end

    sdrc_arb_tag_fifo #(.DEPTH(TAG_DEPTH), .W(ID_W)) u_wr_fifo (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .push         (push_wr),
        .din          (sel_q),
        .pop          (pop_wr),
        .dout         (wsel),
        .full         (wr_full),
        .empty        (wr_empty)
    );

    sdrc_arb_tag_fifo #(.DEPTH(TAG_DEPTH), .W(ID_W)) u_rd_fifo (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .push         (push_rd),
        .din          (sel_q),
        .pop          (pop_rd),
        .dout         (rsel),
        .full         (rd_full),
        .empty        (rd_empty)
    );

    // Write beats: the oldest accepted write owns the data path until its
    // last beat. With no owner the byte enables are forced inactive.
    always_comb begin
        wr_next_o   = '0;
        app_wr_data = '0;
        app_wr_en_n = '1;
        for (int k = 0; k < NREQ; k++) begin
            if (!wr_empty && wsel == ID_W'(k)) begin
                wr_next_o[k] = app_wr_next_req;
                app_wr_data  = wr_data_i[k*APP_DW +: APP_DW];
                app_wr_en_n  = wr_en_n_i[k*APP_BW +: APP_BW];
            end
        end
    end

    assign pop_wr = app_wr_next_req && app_last_wr && !wr_empty;

    // Read beats: data is broadcast, only the qualifiers are steered.
    assign rd_data_o = app_rd_data;

    always_comb begin
        rd_valid_o = '0;
        last_rd_o  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rd_empty && rsel == ID_W'(k)) begin
                rd_valid_o[k] = app_rd_valid;
                last_rd_o[k]  = app_rd_valid && app_last_rd;
            end
        end
    end

    assign pop_rd = app_rd_valid && app_last_rd && !rd_empty;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn)
            arb_err <= 1'b0;
        else if ((app_wr_next_req && wr_empty) || (app_rd_valid && rd_empty))
            arb_err <= 1'b1;
    end

endmodule
